// File: rtl/divider.sv
// Iterative 32-bit restoring divider: lo = quotient, hi = remainder.
// Signed ops divide magnitudes and fix the signs in a final cycle.
module divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        fim,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sgn;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [5:0]  count;
    logic        sign_q;
    logic        sign_r;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign fim     = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = PREP;
            PREP: state_nxt = (op_b == 32'd0) ? IDLE : ITER;
            ITER: if (count == 6'd1) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            sgn      <= 1'b0;
            quo      <= '0;
            dvs      <= '0;
            rem      <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a     <= operand1;
                        op_b     <= operand2;
                        sgn      <= signed_op;
                        div_zero <= 1'b0;
                    end
                end
                PREP: begin
                    if (op_b == 32'd0) begin
                        hi       <= op_a;
                        lo       <= 32'hFFFF_FFFF;
                        div_zero <= 1'b1;
                    end else begin
                        // 32-bit magnitudes keep |0x80000000| exact
                        quo    <= (sgn && op_a[31]) ? -op_a : op_a;
                        dvs    <= (sgn && op_b[31]) ? -op_b : op_b;
                        sign_q <= sgn & (op_a[31] ^ op_b[31]);
                        sign_r <= sgn & op_a[31];
                        rem    <= '0;
                        count  <= 6'd32;
                    end
                end
                ITER: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    count <= count - 6'd1;
                end
                FIX: begin
                    lo <= sign_q ? -quo : quo;
                    hi <= sign_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed cases, timing and random ops.
module tb_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        fim;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    divider dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .signed_op(signed_op),
        .operand1 (operand1),
        .operand2 (operand2),
        .fim      (fim),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference built on the simulator's own / and % over magnitudes
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        exp_t e;
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
            return e;
        end
        ma = (s && a[31]) ? (32'd0 - a) : a;
        mb = (s && b[31]) ? (32'd0 - b) : b;
        q = ma / mb;
        r = ma % mb;
        e.lo = (s && (a[31] ^ b[31])) ? (32'd0 - q) : q;
        e.hi = (s && a[31]) ? (32'd0 - r) : r;
        e.dz = 1'b0;
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input exp_t e);
        operand1  = a;
        operand2  = b;
        signed_op = s;
        start     = 1'b1;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!fim && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l,
                                input logic d);
        exp_t e;
        e.hi = h; e.lo = l; e.dz = d;
        return e;
    endfunction

    task automatic test_reset();
        checks++;
        if ({fim, hi, lo, div_zero} !== {1'b1, 32'd0, 32'd0, 1'b0})
            $display("FAIL reset: fim=%b hi=%h lo=%h dz=%b want 1/0/0/0",
                     fim, hi, lo, div_zero);
        else passed++;
    endtask

    task automatic test_signed();
        logic [31:0] a [2] = '{32'd100, 32'hFFFF_FF9C};
        exp_t ex [2];
        int n;
        exp_t e;
        ex[0] = mk(32'd2, 32'd14, 1'b0);
        ex[1] = mk(32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            issue(a[i], 32'd7, 1'b1, ex[i]);
            checks++;
            if (fim !== 1'b0) $display("FAIL signed_busy%0d: fim=%b want 0", i, fim);
            else passed++;
            wait_done(n);
            checks++;
            if (n !== 34) $display("FAIL signed_lat%0d: got %0d want 34", i, n);
            else passed++;
            e = exp_q.pop_front();
            checks++;
            if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
                $display("FAIL signed%0d: hi=%h lo=%h dz=%b want %h %h %b",
                         i, hi, lo, div_zero, e.hi, e.lo, e.dz);
            else passed++;
        end
    endtask

    task automatic test_div2();
        logic [31:0] a [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] b [3] = '{32'd2, 32'd2, 32'hFFFF_FFFF};
        logic        s [3] = '{1'b0, 1'b1, 1'b1};
        exp_t ex [3];
        int n;
        exp_t e;
        ex[0] = mk(32'd1, 32'h7FFF_FFFF, 1'b0);
        ex[1] = mk(32'hFFFF_FFFF, 32'd0, 1'b0);
        ex[2] = mk(32'd0, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(a[i], b[i], s[i], ex[i]);
            wait_done(n);
            e = exp_q.pop_front();
            checks++;
            if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || n !== 34)
                $display("FAIL div2_%0d: hi=%h lo=%h dz=%b n=%0d want %h %h %b 34",
                         i, hi, lo, div_zero, n, e.hi, e.lo, e.dz);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        int n;
        exp_t e;
        issue(32'h1234_5678, 32'd0, 1'b0, mk(32'h1234_5678, 32'hFFFF_FFFF, 1'b1));
        wait_done(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 1) $display("FAIL dz_lat: got %0d want 1", n);
        else passed++;
        checks++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
            $display("FAIL dz_result: hi=%h lo=%h dz=%b want %h %h %b",
                     hi, lo, div_zero, e.hi, e.lo, e.dz);
        else passed++;
        issue(32'd9, 32'd3, 1'b1, mk(32'd0, 32'd3, 1'b0));
        checks++;
        if (div_zero !== 1'b0) $display("FAIL dz_clear: dz=%b want 0", div_zero);
        else passed++;
        wait_done(n);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
            $display("FAIL dz_next: hi=%h lo=%h dz=%b want %h %h %b",
                     hi, lo, div_zero, e.hi, e.lo, e.dz);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int n;
        exp_t e;
        issue(32'd100, 32'd7, 1'b1, mk(32'd2, 32'd14, 1'b0));
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if ({hi, lo} !== {32'd0, 32'd3})
            $display("FAIL hold: hi=%h lo=%h want 0 3", hi, lo);
        else passed++;
        operand1 = 32'd50;
        operand2 = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(n);
        e = exp_q.pop_front();
        checks++;
        if (n + 10 !== 34) $display("FAIL ign_lat: got %0d want 34", n + 10);
        else passed++;
        checks++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz})
            $display("FAIL ign_result: hi=%h lo=%h want %h %h", hi, lo, e.hi, e.lo);
        else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (fim !== 1'b1) $display("FAIL ign_queued: fim=%b want 1", fim);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int n;
        exp_t e;
        issue(32'd100, 32'd7, 1'b1, mk(32'd2, 32'd14, 1'b0));
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        checks++;
        if ({fim, hi, lo, div_zero} !== {1'b1, 32'd0, 32'd0, 1'b0})
            $display("FAIL abort: fim=%b hi=%h lo=%h dz=%b want 1/0/0/0",
                     fim, hi, lo, div_zero);
        else passed++;
        issue(32'd9, 32'd3, 1'b0, mk(32'd0, 32'd3, 1'b0));
        wait_done(n);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || n !== 34)
            $display("FAIL after_abort: hi=%h lo=%h n=%0d want %h %h 34",
                     hi, lo, n, e.hi, e.lo);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3] = '{32'd1000, 32'd7, 32'd0};
        logic [31:0] b [3] = '{32'd10, 32'hFFFF_FFFE, 32'd5};
        logic        s [3] = '{1'b0, 1'b1, 1'b1};
        exp_t ex [3];
        int n;
        exp_t e;
        ex[0] = mk(32'd0, 32'd100, 1'b0);
        ex[1] = mk(32'd1, 32'hFFFF_FFFD, 1'b0);
        ex[2] = mk(32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(a[i], b[i], s[i], ex[i]);
            wait_done(n);
            e = exp_q.pop_front();
            checks++;
            if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || n !== 34)
                $display("FAIL b2b%0d: hi=%h lo=%h n=%0d want %h %h 34",
                         i, hi, lo, n, e.hi, e.lo);
            else passed++;
        end
    endtask

    task automatic test_random();
        int n;
        exp_t e;
        logic [31:0] a, b, mb, mh;
        logic s;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(1, 15);
                1: b = 32'd0 - $urandom_range(1, 15);
                2: b = (i % 50 == 0) ? 32'd0 : $urandom_range(1, 1000);
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, model(a, b, s));
            wait_done(n);
            e = exp_q.pop_front();
            checks++;
            if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || !fim)
                $display("FAIL rand%0d %h/%h s=%b: hi=%h lo=%h dz=%b want %h %h %b",
                         i, a, b, s, hi, lo, div_zero, e.hi, e.lo, e.dz);
            else passed++;
            if (b != 32'd0) begin
                mb = (s && b[31]) ? (32'd0 - b) : b;
                mh = (s && hi[31]) ? (32'd0 - hi) : hi;
                checks++;
                if (lo * b + hi !== a)
                    $display("FAIL rand_identity%0d: lo*b+hi=%h want %h",
                             i, lo * b + hi, a);
                else passed++;
                checks++;
                if (!(mh < mb))
                    $display("FAIL rand_mag%0d: |hi|=%h want < %h", i, mh, mb);
                else passed++;
                checks++;
                if (s && hi != 32'd0 && hi[31] !== a[31])
                    $display("FAIL rand_sign%0d: hi=%h want sign %b", i, hi, a[31]);
                else passed++;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        operand1  = '0;
        operand2  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        test_reset();
        test_signed();
        test_div2();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
